// File: rtl/bcd_timer_core.sv
// Stopwatch/timer core: N-digit BCD up/down counter stepped by an internal
// prescaler, with start/stop toggle, preset load, terminal detect and mode-change reload.
module bcd_timer_core #(
  parameter int NUM_DIGITS    = 4,
  parameter int PRESET_DIGITS = 2,
  parameter int CLK_HZ        = 100_000_000,
  parameter int TICK_HZ       = 100
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [1:0]                 mode,
  input  logic                       start_stop,
  input  logic [4*PRESET_DIGITS-1:0] preset,
  output logic [4*NUM_DIGITS-1:0]    count,
  output logic                       running,
  output logic                       done,
  output logic                       tick
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int CW  = 4 * NUM_DIGITS;
  localparam logic [CW-1:0] MAX_CNT = {NUM_DIGITS{4'd9}};
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

  typedef enum logic [1:0] {
    M_UP_ZERO = 2'b00,
    M_UP_PRE  = 2'b01,
    M_DN_MAX  = 2'b10,
    M_DN_PRE  = 2'b11
  } mode_e;

  logic [CW-1:0] count_q, count_d;
  logic          running_q, running_d;
  logic          done_q, done_d;
  logic          tick_q, tick_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          ss_prev_q;
  logic [1:0]    mode_q;

  logic [CW-1:0] init_cnt, step_cnt, term_cnt;
  logic          rise, count_up;

  function automatic logic [CW-1:0] init_of(input logic [1:0] m,
                                             input logic [4*PRESET_DIGITS-1:0] p);
    logic [CW-1:0] r;
    logic [3:0]    nib;
    r = '0;
    case (mode_e'(m))
      M_UP_ZERO: r = '0;
      M_DN_MAX:  r = MAX_CNT;
      default: begin
        for (int i = 0; i < PRESET_DIGITS; i++) begin
          nib = p[4*i +: 4];
          r[4*(i + NUM_DIGITS - PRESET_DIGITS) +: 4] = (nib > 4'd9) ? 4'd9 : nib;
        end
      end
    endcase
    return r;
  endfunction

  function automatic logic [CW-1:0] bcd_inc(input logic [CW-1:0] v);
    logic [CW-1:0] r;
    logic          c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (c) begin
        if (v[4*i +: 4] == 4'd9) r[4*i +: 4] = 4'd0;
        else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [CW-1:0] bcd_dec(input logic [CW-1:0] v);
    logic [CW-1:0] r;
    logic          b;
    r = v;
    b = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (b) begin
        if (v[4*i +: 4] == 4'd0) r[4*i +: 4] = 4'd9;
        else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          b = 1'b0;
        end
      end
    end
    return r;
  endfunction

  always_comb begin
    init_cnt = init_of(mode, preset);
    count_up = ~mode[1];
    term_cnt = count_up ? MAX_CNT : '0;
    step_cnt = count_up ? bcd_inc(count_q) : bcd_dec(count_q);
    rise     = start_stop & ~ss_prev_q;
  end

  // Priority: mode change > start/stop edge > prescaler step.
  always_comb begin
    count_d   = count_q;
    running_d = running_q;
    done_d    = done_q;
    presc_d   = presc_q;
    if (mode != mode_q) begin
      count_d   = init_cnt;
      running_d = 1'b0;
      done_d    = 1'b0;
      presc_d   = '0;
    end else if (rise && !done_q) begin
      if (running_q) running_d = 1'b0;
      else if (count_q == term_cnt) done_d = 1'b1;
      else begin
        running_d = 1'b1;
        presc_d   = '0;
      end
    end else if (running_q) begin
      if (presc_q == PRE_LAST) begin
        presc_d = '0;
        count_d = step_cnt;
        if (step_cnt == term_cnt) begin
          running_d = 1'b0;
          done_d    = 1'b1;
        end
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end
    // tick is registered, so it is high during the cycle whose closing edge steps.
    tick_d = running_d && (presc_d == PRE_LAST);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q   <= init_cnt;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      tick_q    <= 1'b0;
      presc_q   <= '0;
      ss_prev_q <= start_stop;
      mode_q    <= mode;
    end else begin
      count_q   <= count_d;
      running_q <= running_d;
      done_q    <= done_d;
      tick_q    <= tick_d;
      presc_q   <= presc_d;
      ss_prev_q <= start_stop;
      mode_q    <= mode;
    end
  end

  assign count   = count_q;
  assign running = running_q;
  assign done    = done_q;
  assign tick    = tick_q;

endmodule

// File: tb/tb_bcd_timer_core.sv
// Bench for bcd_timer_core: directed scenarios plus random stimulus, each cycle
// compared against an integer-valued reference model of the timer.
module tb_bcd_timer_core;
  localparam int N      = 4;
  localparam int P      = 2;
  localparam int CLK_HZ = 10;
  localparam int TICK_HZ = 1;
  localparam int DIV    = CLK_HZ / TICK_HZ;

  logic             clk = 1'b0;
  logic             reset;
  logic [1:0]       mode;
  logic             start_stop;
  logic [4*P-1:0]   preset;
  logic [4*N-1:0]   count;
  logic             running, done, tick;

  bcd_timer_core #(.NUM_DIGITS(N), .PRESET_DIGITS(P), .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ)) dut (
    .clk(clk), .reset(reset), .mode(mode), .start_stop(start_stop), .preset(preset),
    .count(count), .running(running), .done(done), .tick(tick)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int tick_seen = 0;

  // reference state: count held as a plain integer
  int         m_val, m_pre;
  bit         m_run, m_done, m_tick, m_prev;
  logic [1:0] m_mode;

  logic [1:0]     cur_mode = 2'b00;
  logic [4*P-1:0] cur_pre  = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int p10(input int e);
    int r = 1;
    for (int i = 0; i < e; i++) r = r * 10;
    return r;
  endfunction

  function automatic int init_val(input logic [1:0] md, input logic [4*P-1:0] pr);
    int pv = 0;
    int d;
    if (md == 2'b00) return 0;
    if (md == 2'b10) return p10(N) - 1;
    for (int i = 0; i < P; i++) begin
      d = int'(pr[4*i +: 4]);
      if (d > 9) d = 9;
      pv += d * p10(i);
    end
    return pv * p10(N - P);
  endfunction

  function automatic int term_val(input logic [1:0] md);
    return md[1] ? 0 : p10(N) - 1;
  endfunction

  function automatic logic [4*N-1:0] to_bcd(input int v);
    logic [4*N-1:0] r = '0;
    for (int i = 0; i < N; i++) r[4*i +: 4] = 4'((v / p10(i)) % 10);
    return r;
  endfunction

  // one clock: drive inputs, advance the model at the edge, compare after it
  task automatic cyc(input bit r, input logic [1:0] md, input bit ss, input logic [4*P-1:0] pr);
    bit rise;
    reset = r; mode = md; start_stop = ss; preset = pr;
    @(posedge clk);
    if (r) begin
      m_val = init_val(md, pr); m_run = 0; m_done = 0; m_pre = 0;
      m_prev = ss; m_mode = md;
    end else begin
      rise = ss && !m_prev;
      m_prev = ss;
      if (md !== m_mode) begin
        m_mode = md; m_val = init_val(md, pr); m_run = 0; m_done = 0; m_pre = 0;
      end else if (rise && !m_done) begin
        if (m_run) m_run = 0;
        else if (m_val == term_val(md)) m_done = 1;
        else begin m_run = 1; m_pre = 0; end
      end else if (m_run) begin
        if (m_pre == DIV - 1) begin
          m_pre = 0;
          m_val = m_val + (md[1] ? -1 : 1);
          if (m_val == term_val(md)) begin m_run = 0; m_done = 1; end
        end else m_pre++;
      end
    end
    m_tick = m_run && (m_pre == DIV - 1);
    #1;
    if (tick === 1'b1) tick_seen++;
    chk("count",   32'(count),   32'(to_bcd(m_val)));
    chk("running", 32'(running), 32'(m_run));
    chk("done",    32'(done),    32'(m_done));
    chk("tick",    32'(tick),    32'(m_tick));
  endtask

  task automatic do_reset(input logic [1:0] md, input logic [4*P-1:0] pr);
    cur_mode = md; cur_pre = pr;
    cyc(1, md, 0, pr);
    cyc(1, md, 0, pr);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, cur_mode, 0, cur_pre);
  endtask

  task automatic pulse();
    cyc(0, cur_mode, 1, cur_pre);
  endtask

  initial begin
    bit ss_lvl;
    // 1: count up from zero, ten steps
    do_reset(2'b00, 8'h00);
    chk("s1_rst_count", 32'(count), 32'h0000);
    chk("s1_rst_run", 32'(running), 32'd0);
    pulse();
    tick_seen = 0;
    idle(10*DIV + 2);
    chk("s1_count", 32'(count), 32'h0010);
    chk("s1_ticks", 32'(tick_seen), 32'd10);

    // 2: down from preset, borrow, stop/restart
    do_reset(2'b11, 8'h12);
    chk("s2_init", 32'(count), 32'h1200);
    pulse(); idle(DIV);
    chk("s2_borrow", 32'(count), 32'h1199);
    idle(4); pulse(); idle(20);
    chk("s2_frozen", 32'(count), 32'h1199);
    chk("s2_stopped", 32'(running), 32'd0);
    pulse(); idle(DIV - 1);
    chk("s2_not_yet", 32'(count), 32'h1199);
    idle(1);
    chk("s2_restep", 32'(count), 32'h1198);

    // 3: count up to MAX, done on the same edge, later starts ignored
    do_reset(2'b01, 8'h99);
    chk("s3_init", 32'(count), 32'h9900);
    pulse(); idle(99*DIV - 1);
    chk("s3_pre_max", 32'(count), 32'h9998);
    idle(1);
    chk("s3_max", 32'(count), 32'h9999);
    chk("s3_done", 32'(done), 32'd1);
    chk("s3_run", 32'(running), 32'd0);
    idle(3); pulse(); idle(15); pulse(); idle(15);
    chk("s3_hold", 32'(count), 32'h9999);
    chk("s3_hold_run", 32'(running), 32'd0);

    // 4: count down to zero, no wrap; start at terminal
    do_reset(2'b11, 8'h01);
    chk("s4_init", 32'(count), 32'h0100);
    pulse(); idle(100*DIV);
    chk("s4_zero", 32'(count), 32'h0000);
    chk("s4_done", 32'(done), 32'd1);
    idle(30);
    chk("s4_nowrap", 32'(count), 32'h0000);
    do_reset(2'b11, 8'h00);
    pulse(); idle(1);
    chk("s4_term_start_done", 32'(done), 32'd1);
    chk("s4_term_start_run", 32'(running), 32'd0);

    // 5: mode change beats a simultaneous start/stop rise
    do_reset(2'b00, 8'h00);
    pulse(); idle(42*DIV + 3);
    chk("s5_count", 32'(count), 32'h0042);
    cur_mode = 2'b01; cur_pre = 8'h37;
    cyc(0, cur_mode, 1, cur_pre);
    chk("s5_reload", 32'(count), 32'h3700);
    chk("s5_run", 32'(running), 32'd0);
    chk("s5_done", 32'(done), 32'd0);
    idle(15);
    chk("s5_idle", 32'(count), 32'h3700);

    // 6: preset clamp, button held through reset, reset mid-run
    cur_mode = 2'b01; cur_pre = 8'hA5;
    cyc(1, cur_mode, 1, cur_pre);
    cyc(1, cur_mode, 1, cur_pre);
    chk("s6_clamp", 32'(count), 32'h9500);
    for (int i = 0; i < 10; i++) cyc(0, cur_mode, 1, cur_pre);
    chk("s6_no_start", 32'(running), 32'd0);
    idle(2); pulse(); idle(25);
    chk("s6_running", 32'(running), 32'd1);
    cyc(1, cur_mode, 0, cur_pre);
    chk("s6_reinit", 32'(count), 32'h9500);
    chk("s6_rst_run", 32'(running), 32'd0);

    // random phase
    ss_lvl = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 63) == 0) cur_mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) cur_pre = 8'($urandom);
      if ($urandom_range(0, 19) == 0) ss_lvl = ~ss_lvl;
      cyc(($urandom_range(0, 199) == 0), cur_mode, ss_lvl, cur_pre);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
